// File: rtl/exec_stage_p.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | exec_stage_p : execute stage with ALU, load/store address, ldi, compare   |
// | Optional macro EXEC_MUL_EN enables an iterative shift-add multiplier.     |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module exec_stage_p #(
   parameter int WIDTH  = 16,
   parameter int RA_W   = 3,
   parameter int DISP_W = 6,
   parameter int IMM_W  = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              pc_w,
   input  logic              mem_w,
   input  logic              is_eq,
   input  logic              is_ldi,
   input  logic              is_ld_st,
   input  logic              is_jump,
   input  logic [1:0]        alu_op,
   input  logic [RA_W-1:0]   rd_addr,
   input  logic [DISP_W-1:0] disp,
   input  logic [IMM_W-1:0]  imm,
   input  logic [WIDTH-1:0]  rd,
   input  logic [WIDTH-1:0]  rs,
   input  logic [WIDTH-1:0]  src1,
   input  logic [WIDTH-1:0]  src2,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              pc_w_out,
   output logic              mem_w_out,
   output logic [RA_W-1:0]   result_w,
   output logic [WIDTH-1:0]  result,
   output logic [WIDTH-1:0]  rd_out,
   output logic              busy
);

`ifdef EXEC_MUL_EN
   typedef enum logic [1:0] {IDLE = 2'b00, FULL = 2'b01, MUL = 2'b10} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'b00, FULL = 2'b01} state_t;
`endif

   state_t           state;
   state_t           state_nx;
   state_t           load_state;
   logic             accept;
   logic             take;
   logic             cmp;
   logic [WIDTH-1:0] alu_res;
   logic [WIDTH-1:0] sel_res;

   assign in_ready  = (state == IDLE) | ((state == FULL) & out_ready);
   assign accept    = in_valid & in_ready;
   // A flush voids any transfer offered in the same cycle.
   assign take      = accept & ~flush;
   assign out_valid = (state == FULL);
   assign cmp       = is_jump | (is_eq ? (rd == rs) : (rd > rs));

`ifdef EXEC_MUL_EN
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   logic             is_mul;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] acc_nx;

   assign is_mul     = (alu_op == 2'b11) & ~is_ldi & ~is_ld_st;
   assign load_state = is_mul ? MUL : FULL;
   assign busy       = (state == MUL);
   assign acc_nx     = result + (mplier[0] ? mcand : '0);
`else
   assign load_state = FULL;
   assign busy       = 1'b0;
`endif

   always_comb begin
      alu_res = '0;
      case (alu_op)
         2'b00:   alu_res = src1 + src2;
         2'b01:   alu_res = src1 - src2;
         2'b10:   alu_res = src1 & src2;
`ifdef EXEC_MUL_EN
         default: alu_res = '0;
`else
         default: alu_res = src1 | src2;
`endif
      endcase
      if (is_ldi)
         sel_res = WIDTH'(imm);
      else if (is_ld_st)
         sel_res = rs + WIDTH'(disp);
      else
         sel_res = alu_res;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (take) state_nx = load_state;
         FULL: if (out_ready) state_nx = take ? load_state : IDLE;
`ifdef EXEC_MUL_EN
         MUL:  if (cnt == LAST) state_nx = FULL;
`endif
         default: state_nx = IDLE;
      endcase
      if (flush)
         state_nx = IDLE;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_w_out  <= 1'b0;
         mem_w_out <= 1'b0;
         result_w  <= '0;
         rd_out    <= '0;
         result    <= '0;
`ifdef EXEC_MUL_EN
         mcand     <= '0;
         mplier    <= '0;
         cnt       <= '0;
`endif
      end else if (take) begin
         pc_w_out  <= pc_w & cmp;
         mem_w_out <= mem_w;
         result_w  <= rd_addr;
         rd_out    <= rd;
`ifdef EXEC_MUL_EN
         // The result register doubles as the multiply accumulator.
         result    <= is_mul ? '0 : sel_res;
         mcand     <= src1;
         mplier    <= src2;
         cnt       <= '0;
`else
         result    <= sel_res;
`endif
      end
`ifdef EXEC_MUL_EN
      else if (flush) begin
         cnt <= '0;
      end else if (state == MUL) begin
         result <= acc_nx;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
`endif
   end

endmodule
`default_nettype wire

// File: tb/tb_exec_stage_p.sv
`default_nettype none
// Randomized scoreboard bench for exec_stage_p against an arithmetic reference model.
module tb_exec_stage_p;
   localparam int WIDTH  = 16;
   localparam int RA_W   = 3;
   localparam int DISP_W = 6;
   localparam int IMM_W  = 9;
`ifdef EXEC_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
   logic pc_w, mem_w, is_eq, is_ldi, is_ld_st, is_jump, pc_w_out, mem_w_out;
   logic [1:0]        alu_op;
   logic [RA_W-1:0]   rd_addr, result_w;
   logic [DISP_W-1:0] disp;
   logic [IMM_W-1:0]  imm;
   logic [WIDTH-1:0]  rd, rs, src1, src2, result, rd_out;

   exec_stage_p #(.WIDTH(WIDTH), .RA_W(RA_W), .DISP_W(DISP_W), .IMM_W(IMM_W)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .pc_w(pc_w), .mem_w(mem_w), .is_eq(is_eq), .is_ldi(is_ldi), .is_ld_st(is_ld_st),
      .is_jump(is_jump), .alu_op(alu_op), .rd_addr(rd_addr), .disp(disp), .imm(imm),
      .rd(rd), .rs(rs), .src1(src1), .src2(src2), .out_valid(out_valid),
      .out_ready(out_ready), .pc_w_out(pc_w_out), .mem_w_out(mem_w_out),
      .result_w(result_w), .result(result), .rd_out(rd_out), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [WIDTH-1:0] res;
      logic [WIDTH-1:0] rdv;
      logic [RA_W-1:0]  rw;
      logic             pcw;
      logic             memw;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   bit   started = 1'b0;
   bit   m_full = 1'b0;
   bit   m_busy = 1'b0;
   int   m_left = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model_op();
      exp_t        e;
      logic [31:0] s;
      case (alu_op)
         2'd0:    s = 32'(src1) + 32'(src2);
         2'd1:    s = 32'(src1) - 32'(src2);
         2'd2:    s = 32'(src1 & src2);
         default: s = MUL_EN ? 32'(src1) * 32'(src2) : 32'(src1 | src2);
      endcase
      if (is_ldi)        s = 32'(imm);
      else if (is_ld_st) s = 32'(rs) + 32'(disp);
      e.res  = s[WIDTH-1:0];
      e.rdv  = rd;
      e.rw   = rd_addr;
      e.pcw  = pc_w & (is_jump ? 1'b1 : (is_eq ? (rd == rs) : (rd > rs)));
      e.memw = mem_w;
      return e;
   endfunction

   function automatic bit model_ready();
      return !m_busy && (!m_full || out_ready);
   endfunction

   // Advance the reference model over one rising edge using the inputs held across it.
   task automatic step();
      bit rdy;
      @(posedge clk);
      rdy = model_ready();
      if (!rst_n || flush) begin
         m_full = 1'b0;
         m_busy = 1'b0;
         sb.delete();
      end else begin
         if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
               m_busy = 1'b0;
               m_full = 1'b1;
            end
         end else if (m_full && out_ready) begin
            m_full = 1'b0;
         end
         if (in_valid && rdy) begin
            sb.push_back(model_op());
            if (MUL_EN && alu_op == 2'd3 && !is_ldi && !is_ld_st) begin
               m_busy = 1'b1;
               m_left = WIDTH;
               m_full = 1'b0;
            end else begin
               m_full = 1'b1;
            end
         end
      end
      #1;
   endtask

   always @(negedge clk) begin
      if (started) begin
         check("in_ready", in_ready, model_ready());
         check("out_valid", out_valid, m_full);
         check("busy", busy, m_busy);
         if (out_valid) begin
            if (sb.size() == 0) begin
               check("unexpected_output", 1, 0);
            end else begin
               check("result", result, sb[0].res);
               check("rd_out", rd_out, sb[0].rdv);
               check("result_w", result_w, sb[0].rw);
               check("pc_w_out", pc_w_out, sb[0].pcw);
               check("mem_w_out", mem_w_out, sb[0].memw);
               if (out_ready) void'(sb.pop_front());
            end
         end
      end
   end

   task automatic clear_ops();
      {pc_w, mem_w, is_eq, is_ldi, is_ld_st, is_jump} = '0;
      alu_op = 2'd0; rd_addr = '0; disp = '0; imm = '0;
      rd = '0; rs = '0; src1 = '0; src2 = '0;
   endtask

   task automatic issue();
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_result"}, result, 0);
      check({tag, "_rd_out"}, rd_out, 0);
      check({tag, "_result_w"}, result_w, 0);
      check({tag, "_pc_w_out"}, pc_w_out, 0);
      check({tag, "_mem_w_out"}, mem_w_out, 0);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_in_ready"}, in_ready, 1);
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      clear_ops();
      step();
      started = 1'b1;
      step();
      check_zero("reset");
      rst_n = 1'b1;

      // Wrapping add, ldi priority, ld/st address, compare cases.
      src1 = 16'hFFFF; src2 = 16'h0002; alu_op = 2'd0; rd_addr = 3'd5; issue();
      clear_ops(); is_ldi = 1'b1; is_ld_st = 1'b1; imm = 9'h1FF; rs = 16'h0010; disp = 6'h3F; issue();
      clear_ops(); is_ld_st = 1'b1; rs = 16'h0010; disp = 6'h3F; mem_w = 1'b1; issue();
      clear_ops(); pc_w = 1'b1; rd = 16'd5; rs = 16'd7; issue();
      rd = 16'd7; rs = 16'd5; issue();
      rd = 16'd5; rs = 16'd7; is_jump = 1'b1; issue();
      clear_ops(); pc_w = 1'b1; is_eq = 1'b1; rd = 16'd9; rs = 16'd9; alu_op = 2'd1;
      src1 = 16'h0001; src2 = 16'h0003; issue();

      // Multiply (or OR when the multiplier is compiled out).
      clear_ops(); alu_op = 2'd3; src1 = 16'h0123; src2 = 16'h0100; issue();
      clear_ops();
      for (int i = 0; i < WIDTH + 2; i++) step();

      // Output held under backpressure.
      src1 = 16'h00F0; src2 = 16'h0F0F; alu_op = 2'd2; out_ready = 1'b0; issue();
      for (int i = 0; i < 3; i++) step();
      out_ready = 1'b1; step(); step();

      // Flush part-way through a multiply.
      alu_op = 2'd3; src1 = 16'h1234; src2 = 16'h5678; issue();
      for (int i = 0; i < 5; i++) step();
      flush = 1'b1; step(); flush = 1'b0;
      check("flush_out_valid", out_valid, 0);
      for (int i = 0; i < WIDTH + 2; i++) step();

      // Reset in the middle of a multiply.
      alu_op = 2'd3; src1 = 16'hABCD; src2 = 16'h0077; pc_w = 1'b1; is_jump = 1'b1;
      mem_w = 1'b1; rd = 16'h5555; rd_addr = 3'd7; issue();
      for (int i = 0; i < 7; i++) step();
      rst_n = 1'b0; step(); rst_n = 1'b1;
      check_zero("mid_reset");

      for (int n = 0; n < 4000; n++) begin
         {pc_w, mem_w, is_eq, is_jump} = 4'($urandom);
         is_ldi   = ($urandom_range(0, 99) < 10);
         is_ld_st = ($urandom_range(0, 99) < 15);
         alu_op   = 2'($urandom);
         rd_addr  = RA_W'($urandom);
         disp     = DISP_W'($urandom);
         imm      = IMM_W'($urandom);
         rd       = ($urandom_range(0, 3) == 0) ? rs : WIDTH'($urandom);
         rs       = WIDTH'($urandom);
         src1     = WIDTH'($urandom);
         src2     = WIDTH'($urandom);
         in_valid  = ($urandom_range(0, 99) < 70);
         out_ready = ($urandom_range(0, 99) < 75);
         flush     = ($urandom_range(0, 99) < 3);
         rst_n     = ($urandom_range(0, 199) != 0);
         step();
      end

      rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < WIDTH + 4; i++) step();
      check("drain_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/exec_stage_p.md
EXEC_STAGE_P -- requirements
Module: exec_stage_p

Interface
REQ-001 Parameter WIDTH, default 16: datapath width of operands and result.
REQ-002 Parameter RA_W, default 3: destination register address width.
REQ-003 Parameter DISP_W, default 6: displacement width.
REQ-004 Parameter IMM_W, default 9: immediate width; IMM_W <= WIDTH and DISP_W <= WIDTH.
REQ-005 clk  in  1  the single clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  reset, synchronous and active-low.
REQ-007 flush  in  1  synchronous kill of the in-flight operation.
REQ-008 in_valid  in  1  upstream operation present.
REQ-009 in_ready  out  1  stage can accept this cycle.
REQ-010 pc_w, mem_w, is_eq, is_ldi, is_ld_st, is_jump  in  1 each  decoded control.
REQ-011 alu_op  in  2  00 add, 01 sub, 10 and, 11 mul (or, see REQ-031).
REQ-012 rd_addr  in  RA_W  destination register address.
REQ-013 disp  in  DISP_W; imm  in  IMM_W  zero-extended displacement and immediate.
REQ-014 rd, rs, src1, src2  in  WIDTH each  compare operands and ALU sources.
REQ-015 out_valid  out  1; out_ready  in  1  downstream handshake.
REQ-016 pc_w_out, mem_w_out  out  1; result_w  out  RA_W; result, rd_out  out  WIDTH.
REQ-017 busy  out  1  high while in MUL state.

Function
REQ-018 Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
REQ-019 States: IDLE (output empty), FULL (out_valid=1), MUL (iterating); out_valid = (state==FULL).
REQ-020 in_ready = (IDLE) | (FULL & out_ready); in_ready=0 in MUL.
REQ-021 Result select, priority: is_ldi -> zero-extended imm; else is_ld_st -> rs + zero-extended disp mod 2^WIDTH; else ALU(src1, src2).
REQ-022 Add and sub wrap mod 2^WIDTH; sub = src1 - src2.
REQ-023 cmp = is_jump ? 1 : (is_eq ? rd==rs : rd>rs), unsigned; pc_w_out = pc_w & cmp.
REQ-024 All outputs except in_ready are registered; the accept edge captures mem_w_out, result_w, rd_out, pc_w_out.
REQ-025 Single-cycle op: accept edge loads result, state becomes FULL; out_valid 1 cycle after accept.
REQ-026 Mul (alu_op=11, not is_ldi, not is_ld_st): accept enters MUL and loads operands, step counter = 0; each following edge processes one multiplier bit (shift-add); after the WIDTH-th step, result = low WIDTH bits of product, state FULL. out_valid is WIDTH+1 cycles after accept.
REQ-027 FULL & out_ready & !in_valid -> IDLE; FULL & out_ready & accept -> reload (back-to-back, no bubble).
REQ-028 FULL & !out_ready: all outputs held stable.
REQ-029 flush=1: next state IDLE, MUL aborted, counter cleared; flush overrides a simultaneous accept, which is dropped (in_ready still shown, transfer void).

Reset
REQ-030 rst_n=0 at an edge: state IDLE, out_valid=0, busy=0, pc_w_out=0, mem_w_out=0, result=0, rd_out=0, result_w=0, counter=0; dominates flush and accept, including mid-MUL.

Configuration
REQ-031 Macro EXEC_MUL_EN: defined -> alu_op=11 is the iterative multiply of REQ-026. Undefined -> alu_op=11 is single-cycle bitwise OR, MUL state and counter absent, busy tied 0.

Verification
REQ-032 WIDTH=16, add src1=16'hFFFF src2=16'h0002, out_ready=1 -> next cycle out_valid=1, result=16'h0001.
REQ-033 is_ldi=1 imm=9'h1FF, is_ld_st=1 -> result=16'h01FF (ldi priority); is_ld_st only, rs=16'h0010 disp=6'h3F -> result=16'h004F.
REQ-034 pc_w=1 is_eq=0 rd=5 rs=7 -> pc_w_out=0; rd=7 rs=5 -> 1; is_jump=1 -> 1.
REQ-035 EXEC_MUL_EN, mul 16'h0123 x 16'h0100 -> busy 16 cycles, in_ready=0, then out_valid=1, result=16'h2300; without macro -> 1 cycle, result=16'h0123.
REQ-036 out_ready=0 for 3 cycles in FULL -> outputs unchanged, in_ready=0; flush at MUL step 5 -> IDLE next cycle, no out_valid.
REQ-037 rst_n=0 mid-MUL -> next edge all outputs 0, state IDLE, in_ready=1.
